// File: rtl/period_capture_if.sv
// Valid/ready stream carrying measured event periods from period_capture to its consumer.
`timescale 1ns / 1ps

interface period_capture_if #(
  parameter int unsigned WIDTH = 16
);
  logic             cap_valid;
  logic             cap_ready;
  logic [WIDTH-1:0] cap_data;

  modport master (
    output cap_valid,
    output cap_data,
    input  cap_ready
  );

  modport slave (
    input  cap_valid,
    input  cap_data,
    output cap_ready
  );
endinterface

// File: rtl/period_capture.sv
// Timestamps rising edges of an asynchronous event against a free-running count and
// queues the elapsed periods (mod 2^WIDTH) in a small FIFO drained by valid/ready.
`timescale 1ns / 1ps

module period_capture #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count,
  input  logic              evt,
  input  logic              clr_ovf,
  period_capture_if.master  cap,
  output logic              armed,
  output logic              overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic s1_q, s2_q, s3_q;
  logic rise;

  logic [WIDTH-1:0] prev_q;
  logic             armed_q;
  logic             overflow_q;
  logic [WIDTH-1:0] delta;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    occ_q;
  logic [WIDTH-1:0] head_q, head_d;

  logic empty, full, pop, capture, push, drop;

  // s1 is the metastability stage; rise comes from the two settled stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= evt;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == (PtrW + 1)'(DEPTH));
  assign pop     = ~empty & cap.cap_ready;
  assign capture = rise & armed_q;
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;
  assign delta   = count - prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q     <= '0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (rise) begin
        prev_q  <= count;
        armed_q <= 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Head is kept in its own register so cap_data holds its last value once drained.
  always_comb begin
    head_d = head_q;
    if (push && (empty || (pop && occ_q == (PtrW + 1)'(1)))) begin
      head_d = delta;
    end else if (pop && occ_q > (PtrW + 1)'(1)) begin
      head_d = mem_q[rd_ptr_q + PtrW'(1)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= delta;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        occ_q <= occ_q + (PtrW + 1)'(1);
      end else if (pop && !push) begin
        occ_q <= occ_q - (PtrW + 1)'(1);
      end
      head_q <= head_d;
    end
  end

  assign cap.cap_valid = ~empty;
  assign cap.cap_data  = head_q;
  assign armed         = armed_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_period_capture.sv
// Randomised and directed bench for period_capture with an event-level reference model.
`timescale 1ns / 1ps

module tb_period_capture;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] count = '0;
  logic             evt = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             armed, overflow;

  period_capture_if #(.WIDTH(WIDTH)) cap_if ();

  period_capture #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .evt      (evt),
    .clr_ovf  (clr_ovf),
    .cap      (cap_if),
    .armed    (armed),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: periods are differences of count at the capture edge (two edges after
  // the event is first sampled high); the FIFO is a queue bounded by DEPTH.
  logic [WIDTH-1:0] exp_q[$];
  int               pend_q[$];
  int               ncyc = 0;
  int               m_occ = 0;
  bit               m_armed = 0, m_ovf = 0, m_evt_prev = 0;
  logic [WIDTH-1:0] m_prev = '0;

  always @(negedge clk) begin
    bit pop_m, push_m, drop_m;
    logic [WIDTH-1:0] d;
    if (!rst) begin
      chk("reset_valid", 32'(cap_if.cap_valid), 0);
      chk("reset_data", 32'(cap_if.cap_data), 0);
      chk("reset_armed", 32'(armed), 0);
      chk("reset_ovf", 32'(overflow), 0);
      exp_q.delete();
      pend_q.delete();
      m_occ = 0; m_armed = 0; m_ovf = 0; m_evt_prev = 0; m_prev = '0;
    end else begin
      chk("cap_valid", 32'(cap_if.cap_valid), 32'(m_occ != 0));
      chk("armed", 32'(armed), 32'(m_armed));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      pop_m  = (m_occ != 0) && cap_if.cap_ready;
      push_m = 0;
      drop_m = 0;
      if (pend_q.size() != 0 && pend_q[0] == ncyc) begin
        void'(pend_q.pop_front());
        if (!m_armed) begin
          m_armed = 1;
        end else begin
          d = count - m_prev;
          if (m_occ < DEPTH || pop_m) begin
            exp_q.push_back(d);
            push_m = 1;
          end else begin
            drop_m = 1;
          end
        end
        m_prev = count;
      end
      m_occ = m_occ + int'(push_m) - int'(pop_m);
      if (drop_m) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (evt && !m_evt_prev) pend_q.push_back(ncyc + 2);
      m_evt_prev = evt;
    end
    ncyc++;
  end

  // Monitor: every accepted sample must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && cap_if.cap_valid && cap_if.cap_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(cap_if.cap_data), 32'hdead_beef);
      end else begin
        chk("cap_data", 32'(cap_if.cap_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      count = count + 1'b1;
    end
  endtask

  task automatic pulse_evt(input int high, input int low);
    evt = 1'b1;
    step(high);
    evt = 1'b0;
    step(low);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("async_valid", 32'(cap_if.cap_valid), 0);
    chk("async_armed", 32'(armed), 0);
    step(1);
    rst = 1'b1;
    step(1);
  endtask

  // Capture edge falls two edges after the first sample; hold a side input for that edge.
  task automatic evt_with_side(input bit use_clr, input bit use_ready);
    evt = 1'b1;
    step(2);
    if (use_clr) clr_ovf = 1'b1;
    if (use_ready) cap_if.cap_ready = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    cap_if.cap_ready = 1'b0;
    step(1);
    evt = 1'b0;
    step(8);
  endtask

  initial begin
    int low_left, high_left;
    cap_if.cap_ready = 1'b0;
    // Reset held with evt toggling.
    for (int i = 0; i < 8; i++) begin
      evt = ~evt;
      cap_if.cap_ready = 1'($urandom);
      step(1);
    end
    evt = 1'b0;
    cap_if.cap_ready = 1'b0;
    rst = 1'b1;
    step(5);

    // Basic 100-cycle period.
    cap_if.cap_ready = 1'b1;
    for (int i = 0; i < 5; i++) pulse_evt(4, 96);

    // Wrap-around: capture at 0xFFF0 then 0x0010.
    count = 16'hFFEE;
    pulse_evt(4, 28);
    pulse_evt(4, 28);
    step(5);

    // Full / overflow.
    do_reset();
    cap_if.cap_ready = 1'b0;
    pulse_evt(4, 6);
    pulse_evt(4, 16);
    pulse_evt(4, 26);
    pulse_evt(4, 36);
    pulse_evt(4, 46);
    pulse_evt(4, 10);
    chk("ovf_after_drop", 32'(overflow), 1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    step(2);
    chk("ovf_cleared", 32'(overflow), 0);
    evt_with_side(1'b1, 1'b0);
    chk("ovf_clr_vs_set", 32'(overflow), 1);
    cap_if.cap_ready = 1'b1;
    step(8);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;

    // Full with same-cycle pop.
    cap_if.cap_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse_evt(4, 8);
    evt_with_side(1'b0, 1'b1);
    chk("ovf_with_pop", 32'(overflow), 0);
    cap_if.cap_ready = 1'b1;
    step(8);

    // Reset mid-operation.
    cap_if.cap_ready = 1'b0;
    pulse_evt(4, 20);
    pulse_evt(4, 20);
    do_reset();
    pulse_evt(4, 30);
    pulse_evt(4, 30);
    cap_if.cap_ready = 1'b1;
    step(6);

    // Random traffic.
    low_left  = $urandom_range(2, 40);
    high_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (high_left > 0) begin
        evt = 1'b1;
        high_left--;
        if (high_left == 0) low_left = $urandom_range(2, 40);
      end else begin
        evt = 1'b0;
        low_left--;
        if (low_left == 0) high_left = $urandom_range(2, 10);
      end
      cap_if.cap_ready = ($urandom_range(0, 3) == 0);
      clr_ovf = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 499) == 0) count = 16'($urandom);
      step(1);
    end
    evt = 1'b0;
    clr_ovf = 1'b0;
    cap_if.cap_ready = 1'b1;
    step(12);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
